// File: rtl/i2c_cfg_pkg.sv
// rtl/i2c_cfg_pkg.sv - shared encodings for the I2C config-table sequencer
package i2c_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START_A,
        ST_START_B,
        ST_BYTE,
        ST_ACK,
        ST_STOP_A,
        ST_STOP_B,
        ST_GAP,
        ST_NEXT,
        ST_FIN
    } seq_state_t;

    typedef enum logic [1:0] {
        SEL_ADDR = 2'd0,
        SEL_AREG = 2'd1,
        SEL_DREG = 2'd2
    } byte_sel_t;

    // Quarter phases of one SCL period: q0/q1 SCL held low, q2/q3 released.
    localparam logic [1:0] QPH_0 = 2'd0;
    localparam logic [1:0] QPH_1 = 2'd1;
    localparam logic [1:0] QPH_2 = 2'd2;
    localparam logic [1:0] QPH_3 = 2'd3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// rtl/i2c_qtick_gen.sv - SCL quarter-period tick divider with clock-stretch hold
module i2c_qtick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic clk_40m,
    input  logic rst,
    input  logic run,
    input  logic hold,
    output logic qtick
);

    localparam int             CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // A held counter never reaches its terminal value, so the FSM stalls with it.
    assign qtick = run && !hold && (cnt == LAST);

    // Divider restarts from zero whenever the sequencer is idle.
    always_ff @(posedge clk_40m or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - write-only I2C master replaying a {reg_addr, data} table
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int         CLK_DIV    = 125,
    parameter int         N_REGS     = 11,
    parameter logic [6:0] SLAVE_ADDR = 7'h55,
    parameter int         MAX_RETRY  = 3,
    parameter int         GAP_QTR    = 8
) (
    input  logic       clk_40m,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] tbl_idx,
    input  logic [7:0] tbl_areg,
    input  logic [7:0] tbl_dreg,
    output logic       scl_oe,
    input  logic       scl_i,
    output logic       sda_oe,
    input  logic       sda_i,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] retry_cnt
);

    seq_state_t state, state_n;
    byte_sel_t  byte_sel, sel_n;
    logic [1:0] qph, qph_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shreg, sh_n;
    logic [7:0] gap_cnt, gap_n;
    logic [7:0] try_cnt, try_n;
    logic [7:0] idx_n, retry_n;
    logic       entry_good, good_n;
    logic       ack_bit, ack_n;
    logic       busy_n, done_n, error_n;
    logic       scl_n, sda_n, sda_want, sda_free;
    logic       start_d, start_rise;
    logic       qtick, stretch_hold;

    assign start_rise   = start && !start_d;
    // Slave stretching: we released SCL but the pad is still low.
    assign stretch_hold = !scl_oe && !scl_i;

    i2c_qtick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_qtick (
        .clk_40m (clk_40m),
        .rst     (rst),
        .run     (state != ST_IDLE),
        .hold    (stretch_hold),
        .qtick   (qtick)
    );

    // Next-state, datapath and line-drive decode; all transitions except IDLE/NEXT/FIN wait for qtick.
    always_comb begin
        state_n  = state;
        sel_n    = byte_sel;
        qph_n    = qph;
        bit_n    = bit_cnt;
        sh_n     = shreg;
        gap_n    = gap_cnt;
        try_n    = try_cnt;
        good_n   = entry_good;
        ack_n    = ack_bit;
        idx_n    = tbl_idx;
        retry_n  = retry_cnt;
        busy_n   = busy;
        done_n   = done;
        error_n  = error;
        scl_n    = 1'b0;
        sda_want = 1'b0;
        sda_free = 1'b1;

        case (state)
            ST_IDLE: begin
                if (start_rise) begin
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    error_n = 1'b0;
                    idx_n   = 8'd0;
                    retry_n = 8'd0;
                    try_n   = 8'd0;
                    state_n = ST_START_A;
                end
            end
            ST_START_A: begin
                if (qtick) state_n = ST_START_B;
            end
            ST_START_B: begin
                sda_want = 1'b1;
                if (qtick) begin
                    state_n = ST_BYTE;
                    sel_n   = SEL_ADDR;
                    sh_n    = {SLAVE_ADDR, 1'b0};
                    bit_n   = 3'd0;
                    qph_n   = QPH_0;
                end
            end
            ST_BYTE: begin
                sda_free = 1'b0;
                scl_n    = (qph < QPH_2);
                sda_want = !shreg[7];
                if (qtick) begin
                    qph_n = qph + 2'd1;
                    if (qph == QPH_3) begin
                        if (bit_cnt == 3'd7) begin
                            state_n = ST_ACK;
                        end else begin
                            bit_n = bit_cnt + 3'd1;
                            sh_n  = {shreg[6:0], 1'b0};
                        end
                    end
                end
            end
            ST_ACK: begin
                sda_free = 1'b0;
                scl_n    = (qph < QPH_2);
                if (qtick) begin
                    qph_n = qph + 2'd1;
                    if (qph == QPH_2) ack_n = sda_i;
                    if (qph == QPH_3) begin
                        if (!ack_bit && byte_sel != SEL_DREG) begin
                            sel_n   = (byte_sel == SEL_ADDR) ? SEL_AREG : SEL_DREG;
                            sh_n    = (byte_sel == SEL_ADDR) ? tbl_areg : tbl_dreg;
                            bit_n   = 3'd0;
                            state_n = ST_BYTE;
                        end else if (!ack_bit) begin
                            good_n  = 1'b1;
                            state_n = ST_STOP_A;
                        end else begin
                            retry_n = sat_inc8(retry_cnt);
                            try_n   = sat_inc8(try_cnt);
                            good_n  = 1'b0;
                            state_n = ST_STOP_A;
                        end
                    end
                end
            end
            ST_STOP_A: begin
                sda_free = 1'b0;
                scl_n    = 1'b1;
                sda_want = 1'b1;
                if (qtick) begin
                    qph_n   = QPH_0;
                    state_n = ST_STOP_B;
                end
            end
            ST_STOP_B: begin
                sda_want = (qph == QPH_0);
                if (qtick) begin
                    if (qph == QPH_0) begin
                        qph_n = QPH_1;
                    end else begin
                        gap_n   = 8'd0;
                        state_n = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (qtick) begin
                    if (gap_cnt == 8'(GAP_QTR - 1)) state_n = ST_NEXT;
                    else                            gap_n   = gap_cnt + 8'd1;
                end
            end
            ST_NEXT: begin
                if (entry_good && tbl_idx == 8'(N_REGS - 1)) begin
                    done_n  = 1'b1;
                    state_n = ST_FIN;
                end else if (entry_good) begin
                    idx_n   = tbl_idx + 8'd1;
                    try_n   = 8'd0;
                    state_n = ST_START_A;
                end else if (try_cnt <= 8'(MAX_RETRY)) begin
                    state_n = ST_START_A;
                end else begin
                    error_n = 1'b1;
                    state_n = ST_FIN;
                end
            end
            ST_FIN: begin
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // Inside a frame SDA may only move once SCL is already being held low.
        sda_n = (scl_oe || sda_free) ? sda_want : sda_oe;
    end

    // State, datapath and registered pad drive; async reset releases both lines at once.
    always_ff @(posedge clk_40m or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_sel   <= SEL_ADDR;
            qph        <= QPH_0;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            gap_cnt    <= 8'd0;
            try_cnt    <= 8'd0;
            entry_good <= 1'b0;
            ack_bit    <= 1'b1;
            tbl_idx    <= 8'd0;
            retry_cnt  <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
            start_d    <= 1'b0;
        end else begin
            state      <= state_n;
            byte_sel   <= sel_n;
            qph        <= qph_n;
            bit_cnt    <= bit_n;
            shreg      <= sh_n;
            gap_cnt    <= gap_n;
            try_cnt    <= try_n;
            entry_good <= good_n;
            ack_bit    <= ack_n;
            tbl_idx    <= idx_n;
            retry_cnt  <= retry_n;
            busy       <= busy_n;
            done       <= done_n;
            error      <= error_n;
            scl_oe     <= scl_n;
            sda_oe     <= sda_n;
            start_d    <= start;
        end
    end

endmodule
